// File: rtl/matrix_frame_sequencer.sv
// Frame-load sequencer for the 16-column dot-matrix driver: reads column words from frame memory
// through a scrolled, wrapping window and replays them into Matrix as CLEAR + LOAD strobes.
module matrix_frame_sequencer #(
  parameter int unsigned NUM_COLS     = 16,
  parameter int unsigned FRAME_COLS   = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FRAME_PERIOD = 50000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              auto_en,
  input  logic              scroll_en,
  input  logic [ADDR_W-1:0] scroll_step,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [4:0]        column_id,
  output logic [15:0]       in_column,
  output logic              LOAD,
  output logic              IN_CLR,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] offset,
  output logic              overrun
);

  localparam int unsigned TimerW = $clog2(FRAME_PERIOD);
  localparam int unsigned SumW   = ADDR_W + 1;
  localparam logic [SumW-1:0]   FrameCols = SumW'(FRAME_COLS);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(FRAME_PERIOD - 1);
  localparam logic [4:0]        ColLast   = 5'(NUM_COLS - 1);

  typedef enum logic [2:0] {StIdle, StClear, StRead, StWrite, StDone} state_e;

  state_e              state_q;
  logic [4:0]          col_q;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   mem_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   step_eff;
  logic [SumW-1:0]     rd_raw, rd_wrap, sc_raw, sc_wrap;
  logic [TimerW-1:0]   timer_q;
  logic [4:0]          column_id_q;
  logic [15:0]         in_column_q;
  logic                in_clr_q, mem_rd_q, load_q, done_q, busy_q, overrun_q;
  logic                tick;

  always_comb begin
    tick      = auto_en && (timer_q == TimerLast);
    // Address for the next column; offset < FRAME_COLS so one subtraction always suffices.
    rd_raw    = {1'b0, offset_q} + SumW'(col_q) + SumW'(1);
    rd_wrap   = (rd_raw >= FrameCols) ? rd_raw - FrameCols : rd_raw;
    rd_addr_d = rd_wrap[ADDR_W-1:0];
    step_eff  = ({1'b0, scroll_step} >= FrameCols) ? '0 : scroll_step;
    sc_raw    = {1'b0, offset_q} + {1'b0, step_eff};
    sc_wrap   = (sc_raw >= FrameCols) ? sc_raw - FrameCols : sc_raw;
    offset_d  = sc_wrap[ADDR_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      col_q       <= '0;
      offset_q    <= '0;
      timer_q     <= '0;
      mem_addr_q  <= '0;
      column_id_q <= '0;
      in_column_q <= '0;
      in_clr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      timer_q  <= (timer_q == TimerLast) ? '0 : timer_q + TimerW'(1);
      if (tick && busy_q) overrun_q <= 1'b1;
      in_clr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start || tick) begin
            state_q  <= StClear;
            in_clr_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StClear: begin
          col_q      <= '0;
          state_q    <= StRead;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= offset_q;
        end
        StRead: begin
          state_q     <= StWrite;
          load_q      <= 1'b1;
          column_id_q <= col_q;
        end
        StWrite: begin
          in_column_q <= mem_data;
          if (col_q == ColLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            col_q      <= col_q + 5'd1;
            state_q    <= StRead;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= rd_addr_d;
          end
        end
        StDone: begin
          if (scroll_en) offset_q <= offset_d;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data arrives during WRITE itself, so it is forwarded then and held afterwards.
  assign in_column = load_q ? mem_data : in_column_q;
  assign column_id = column_id_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign LOAD      = load_q;
  assign IN_CLR    = in_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign offset    = offset_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Self-checking bench for matrix_frame_sequencer: frame contents, timing, scroll wrap,
// auto refresh / overrun and mid-frame reset, checked against a frame-level reference model.
module tb_matrix_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, auto_en, scroll_en;
  logic [4:0]  scroll_step;
  logic        mem_rd, LOAD, IN_CLR, busy, done, overrun;
  logic [4:0]  mem_addr, column_id, offset;
  logic [15:0] mem_data, in_column;

  logic        start2, auto_en2, scroll_en2;
  logic [5:0]  scroll_step2, mem_addr2, offset2;
  logic        mem_rd2, LOAD2, IN_CLR2, busy2, done2, overrun2;
  logic [4:0]  column_id2;
  logic [15:0] mem_data2, in_column2;

  matrix_frame_sequencer #(.NUM_COLS(16), .FRAME_COLS(32), .ADDR_W(5), .FRAME_PERIOD(40)) dut (
    .CLK(clk), .RESET(rst), .start(start), .auto_en(auto_en), .scroll_en(scroll_en),
    .scroll_step(scroll_step), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .column_id(column_id), .in_column(in_column), .LOAD(LOAD), .IN_CLR(IN_CLR), .busy(busy),
    .done(done), .offset(offset), .overrun(overrun)
  );

  // Wider address port so that steps >= FRAME_COLS can be presented; short refresh period.
  matrix_frame_sequencer #(.NUM_COLS(16), .FRAME_COLS(32), .ADDR_W(6), .FRAME_PERIOD(20)) dut2 (
    .CLK(clk), .RESET(rst), .start(start2), .auto_en(auto_en2), .scroll_en(scroll_en2),
    .scroll_step(scroll_step2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .column_id(column_id2), .in_column(in_column2), .LOAD(LOAD2), .IN_CLR(IN_CLR2), .busy(busy2),
    .done(done2), .offset(offset2), .overrun(overrun2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= mem[mem_addr];
    if (mem_rd2) mem_data2 <= mem[mem_addr2[4:0]];
  end

  int ld_col[$], ld_dat[$], ld_cyc[$], rd_adr[$], clr_cyc[$], done_cyc[$], clr2_cyc[$];
  int onehot_bad = 0, off_moved = 0;
  logic [4:0] frame_off = '0;

  always @(negedge clk) begin
    if (LOAD) begin
      ld_col.push_back(int'(column_id));
      ld_dat.push_back(int'(in_column));
      ld_cyc.push_back(cyc);
    end
    if (mem_rd) rd_adr.push_back(int'(mem_addr));
    if (IN_CLR) begin
      clr_cyc.push_back(cyc);
      frame_off = offset;
    end
    if (busy && offset != frame_off) off_moved++;
    if (done) done_cyc.push_back(cyc);
    if (int'(IN_CLR) + int'(mem_rd) + int'(LOAD) + int'(done) > 1) onehot_bad++;
    if (IN_CLR2) clr2_cyc.push_back(cyc);
  end

  int n_chk = 0, n_fail = 0;
  int model_off = 0, model2 = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One start-launched frame on the main DUT, checked column by column against the model.
  task automatic run_frame(input bit se, input int step, input bit noisy);
    int s, off, got, ea;
    off = model_off;
    @(negedge clk);
    ld_col.delete(); ld_dat.delete(); ld_cyc.delete(); rd_adr.delete();
    clr_cyc.delete(); done_cyc.delete(); off_moved = 0;
    chk("offset before frame", int'(offset), off);
    scroll_en = se; scroll_step = 5'(step); start = 1'b1; s = cyc;
    got = 0;
    for (int i = 0; i < 80 && got == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (noisy && (cyc - s == 5 || cyc - s == 10)) start = 1'b1;
      if (done) got = 1;
    end
    start = 1'b0;
    if (got == 0) begin
      chk("done timeout", 0, 1);
      return;
    end
    @(negedge clk);
    chk("busy after done", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("IN_CLR count", clr_cyc.size(), 1);
    if (clr_cyc.size() > 0) chk("IN_CLR latency", clr_cyc[0] - s, 1);
    chk("done count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("done latency", done_cyc[0] - s, 34);
    chk("LOAD count", ld_col.size(), 16);
    for (int k = 0; k < 16 && k < ld_col.size(); k++) begin
      ea = (off + k) % 32;
      chk($sformatf("col %0d id", k), ld_col[k], k);
      chk($sformatf("col %0d data", k), ld_dat[k], int'(mem[ea]));
      chk($sformatf("col %0d LOAD cycle", k), ld_cyc[k] - s, 3 + 2 * k);
      if (k < rd_adr.size()) chk($sformatf("col %0d read addr", k), rd_adr[k], ea);
    end
    chk("offset stable in frame", off_moved, 0);
    if (se) model_off = (model_off + (step >= 32 ? 0 : step)) % 32;
    chk("offset after frame", int'(offset), model_off);
  endtask

  task automatic frame2(input int step);
    int got;
    @(negedge clk);
    scroll_en2 = 1'b1; scroll_step2 = 6'(step); start2 = 1'b1;
    got = 0;
    for (int i = 0; i < 80 && got == 0; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) got = 1;
    end
    start2 = 1'b0;
    if (got == 0) chk("dut2 done timeout", 0, 1);
    @(negedge clk);
    model2 = (model2 + (step >= 32 ? 0 : step)) % 32;
    chk($sformatf("dut2 offset after step %0d", step), int'(offset2), model2);
  endtask

  typedef struct {
    bit se;
    int step;
    bit noisy;
    int exp_off;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int c, got;
    tbl[0] = '{1'b0, 0,  1'b0, 0};
    tbl[1] = '{1'b1, 1,  1'b0, 1};
    tbl[2] = '{1'b1, 19, 1'b0, 20};
    tbl[3] = '{1'b1, 20, 1'b0, 8};
    tbl[4] = '{1'b0, 5,  1'b1, 8};
    tbl[5] = '{1'b1, 31, 1'b0, 7};

    rst = 1'b1; start = 1'b0; auto_en = 1'b0; scroll_en = 1'b0; scroll_step = '0;
    start2 = 1'b0; auto_en2 = 1'b0; scroll_en2 = 1'b0; scroll_step2 = '0;
    for (int k = 0; k < 32; k++) mem[k] = 16'h0100 + 16'(k);
    repeat (3) @(negedge clk);
    chk("reset IN_CLR", int'(IN_CLR), 0);
    chk("reset mem_rd", int'(mem_rd), 0);
    chk("reset LOAD", int'(LOAD), 0);
    chk("reset done", int'(done), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(overrun), 0);
    chk("reset offset", int'(offset), 0);
    chk("reset column_id", int'(column_id), 0);
    chk("reset in_column", int'(in_column), 0);
    chk("reset mem_addr", int'(mem_addr), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].se, tbl[i].step, tbl[i].noisy);
      chk($sformatf("table %0d offset", i), int'(offset), tbl[i].exp_off);
    end

    for (int k = 0; k < 32; k++) mem[k] = 16'($urandom);
    for (int i = 0; i < 8; i++)
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    run_frame(1'b1, (37 - model_off) % 32, 1'b0);

    // Auto refresh every 40 cycles, then a start coincident with a tick.
    @(negedge clk);
    scroll_en = 1'b0;
    clr_cyc.delete();
    auto_en = 1'b1;
    repeat (175) @(negedge clk);
    chk("auto frame count ok", int'(clr_cyc.size() >= 4), 1);
    for (int i = 1; i < clr_cyc.size(); i++)
      chk($sformatf("auto spacing %0d", i), clr_cyc[i] - clr_cyc[i-1], 40);
    chk("overrun at period 40", int'(overrun), 0);
    c = (clr_cyc.size() > 0) ? clr_cyc[$] : cyc;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    while (cyc < c + 39) @(negedge clk);
    chk("coincident setup cycle", cyc, c + 39);
    clr_cyc.delete(); ld_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (37) @(negedge clk);
    auto_en = 1'b0;
    chk("coincident IN_CLR count", clr_cyc.size(), 1);
    if (clr_cyc.size() > 0) chk("coincident IN_CLR cycle", clr_cyc[0], c + 40);
    chk("coincident LOAD count", ld_cyc.size(), 16);
    chk("overrun after coincident", int'(overrun), 0);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);

    // Reset in the middle of column 7's WRITE.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      if (LOAD && column_id == 5'd7) got = 1;
      else @(negedge clk);
    end
    chk("reached column 7", got, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset LOAD", int'(LOAD), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset offset", int'(offset), 0);
    chk("mid reset mem_rd", int'(mem_rd), 0);
    chk("mid reset IN_CLR", int'(IN_CLR), 0);
    rst = 1'b0;
    model_off = 0;
    run_frame(1'b0, 0, 1'b0);

    frame2(33);
    frame2(20);
    frame2(33);
    frame2(32);
    frame2(44);
    frame2(12);

    // Period 20 is shorter than a frame: every other tick lands while busy.
    @(negedge clk);
    scroll_en2 = 1'b0;
    chk("dut2 overrun before auto", int'(overrun2), 0);
    clr2_cyc.delete();
    auto_en2 = 1'b1;
    repeat (130) @(negedge clk);
    auto_en2 = 1'b0;
    chk("dut2 overrun set", int'(overrun2), 1);
    chk("dut2 auto frame count ok", int'(clr2_cyc.size() >= 3), 1);
    for (int i = 1; i < clr2_cyc.size(); i++)
      chk($sformatf("dut2 spacing %0d", i), clr2_cyc[i] - clr2_cyc[i-1], 40);
    repeat (40) @(negedge clk);
    chk("dut2 overrun sticky", int'(overrun2), 1);

    chk("strobe exclusivity violations", onehot_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
